// File: rtl/tis_stream_pkg.sv
// Shared stream-port types and constants for the TIS node feeder/checker pair.
package tis_stream_pkg;

  localparam int unsigned WIDTH = 11;
  localparam int unsigned DEPTH = 64;
  localparam int unsigned LEN_W = $clog2(DEPTH);

  typedef logic [WIDTH-1:0] word_t;
  typedef logic [LEN_W-1:0] len_t;

  typedef enum logic {
    IDLE = 1'b0,
    ACK  = 1'b1
  } sink_state_t;

endpackage

// File: rtl/outstream_check_if.sv
// Node stream port handshake: the producer offers a word with write/in, and the
// sink acknowledges it with a one-cycle rready pulse.
//   write  : producer holds high while a word is offered
//   in     : offered word, stable while write is high
//   rready : sink acknowledge; transfer when write && rready at posedge
interface outstream_check_if;
  import tis_stream_pkg::*;

  logic  write;
  word_t in;
  logic  rready;

  modport master (output write, output in, input rready);
  modport slave  (input write, input in, output rready);

endinterface

// File: rtl/outstream_check.sv
// Sink end of a node output stream: acknowledges offered words, captures them in
// order and compares them against an expected list.
//   clk, rst  : clock, asynchronous active-high reset
//   s         : stream handshake (slave side)
//   length    : expected word count, 0 = port unused (static after reset)
//   expected  : expected words, index 0 first
//   captured  : received words in order
//   count     : number of words received
//   done      : count == length && length != 0 (combinational)
//   mismatch  : sticky, some received word differed from expected
//   err_idx   : index of the first mismatching word
//   overflow  : sticky, producer offered a word once full (or port unused)
module outstream_check
  import tis_stream_pkg::*;
(
  input  logic                    clk,
  input  logic                    rst,
  outstream_check_if.slave        s,
  input  len_t                    length,
  input  word_t [DEPTH-1:0]       expected,
  output word_t [DEPTH-1:0]       captured,
  output len_t                    count,
  output logic                    done,
  output logic                    mismatch,
  output len_t                    err_idx,
  output logic                    overflow
);

  sink_state_t       state_q, state_d;
  len_t              count_q, count_d;
  word_t [DEPTH-1:0] captured_q, captured_d;
  logic              mismatch_q, mismatch_d;
  len_t              err_idx_q, err_idx_d;
  logic              overflow_q, overflow_d;

  logic full;

  // Full also covers the unused port (length == 0), so it never acknowledges.
  assign full = (count_q == length);

  // State and capture registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      count_q    <= '0;
      captured_q <= '0;
      mismatch_q <= 1'b0;
      err_idx_q  <= '0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      count_q    <= count_d;
      captured_q <= captured_d;
      mismatch_q <= mismatch_d;
      err_idx_q  <= err_idx_d;
      overflow_q <= overflow_d;
    end
  end

  // Next-state, capture and compare.
  always_comb begin
    state_d    = state_q;
    count_d    = count_q;
    captured_d = captured_q;
    mismatch_d = mismatch_q;
    err_idx_d  = err_idx_q;
    overflow_d = overflow_q;

    unique case (state_q)
      IDLE: begin
        if (s.write) begin
          if (!full) begin
            state_d = ACK;
          end else begin
            overflow_d = 1'b1;
          end
        end
      end
      ACK: begin
        // One-cycle acknowledge; a dropped write simply re-arms from IDLE.
        state_d = IDLE;
        if (s.write) begin
          captured_d[count_q] = s.in;
          count_d             = count_q + LEN_W'(1);
          if ((s.in != expected[count_q]) && !mismatch_q) begin
            mismatch_d = 1'b1;
            err_idx_d  = count_q;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign s.rready = (state_q == ACK);
  assign captured = captured_q;
  assign count    = count_q;
  assign mismatch = mismatch_q;
  assign err_idx  = err_idx_q;
  assign overflow = overflow_q;
  assign done     = full && (length != '0);

endmodule

// File: tb/tb_outstream_check.sv
// Directed bench for outstream_check.
module tb_outstream_check;
  import tis_stream_pkg::*;

  logic              clk;
  logic              rst;
  len_t              length;
  word_t [DEPTH-1:0] expected;
  word_t [DEPTH-1:0] captured;
  len_t              count;
  logic              done;
  logic              mismatch;
  len_t              err_idx;
  logic              overflow;

  outstream_check_if bus ();

  outstream_check dut (
    .clk      (clk),
    .rst      (rst),
    .s        (bus.slave),
    .length   (length),
    .expected (expected),
    .captured (captured),
    .count    (count),
    .done     (done),
    .mismatch (mismatch),
    .err_idx  (err_idx),
    .overflow (overflow)
  );

  int n_checks = 0;
  int n_pass   = 0;
  logic [15:0] hist;
  int xfers;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Count handshakes actually completed.
  always @(posedge clk) begin
    if (!rst && bus.write && bus.rready) xfers <= xfers + 1;
  end

  task automatic apply_reset(input len_t len);
    @(negedge clk);
    rst       = 1'b1;
    bus.write = 1'b0;
    length    = len;
    @(negedge clk);
    rst   = 1'b0;
    xfers = 0;
    hist  = '0;
  endtask

  // Offer one word and wait for its acknowledge; leaves write high on return.
  task automatic send_word(input word_t v, output bit ok);
    bus.write = 1'b1;
    bus.in    = v;
    ok        = 1'b0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      hist = {hist[14:0], bus.rready};
      if (bus.rready) begin
        ok = 1'b1;
        break;
      end
    end
    @(negedge clk);
    hist = {hist[14:0], bus.rready};
  endtask

  task automatic test_reset();
    bit ok;
    expected = '0;
    @(negedge clk);
    rst       = 1'b1;
    length    = 6'd3;
    bus.write = 1'b1;
    bus.in    = 11'd42;
    @(negedge clk);
    @(negedge clk);
    n_checks++;
    if (bus.rready !== 1'b0 || count !== 6'd0 || mismatch !== 1'b0 || overflow !== 1'b0 ||
        err_idx !== 6'd0 || done !== 1'b0)
      $display("FAIL reset_outputs: rready=%b count=%0d mm=%b ov=%b ei=%0d done=%b, want all 0",
               bus.rready, count, mismatch, overflow, err_idx, done);
    else n_pass++;
    n_checks++;
    if (captured !== '0) $display("FAIL reset_captured: captured nonzero, want all 0");
    else n_pass++;
    bus.write = 1'b0;
    rst = 1'b0;
    ok = 1'b1;
  endtask

  task automatic test_match();
    bit ok, all_ok;
    word_t w [3];
    w[0] = 11'd5; w[1] = 11'h7F9; w[2] = 11'd999;
    expected = '0;
    for (int i = 0; i < 3; i++) expected[i] = w[i];
    apply_reset(6'd3);
    all_ok = 1'b1;
    for (int i = 0; i < 3; i++) begin
      send_word(w[i], ok);
      bus.write = 1'b0;
      all_ok &= ok;
      @(negedge clk);
    end
    n_checks++;
    if (!all_ok || xfers != 3) $display("FAIL match_pulses: acks_ok=%b xfers=%0d, want 1 and 3", all_ok, xfers);
    else n_pass++;
    n_checks++;
    if (count !== 6'd3 || done !== 1'b1 || mismatch !== 1'b0)
      $display("FAIL match_status: count=%0d done=%b mm=%b, want 3 1 0", count, done, mismatch);
    else n_pass++;
    n_checks++;
    if (captured[0] !== 11'd5 || captured[1] !== 11'h7F9 || captured[2] !== 11'h3E7 || captured[3] !== 11'd0)
      $display("FAIL match_captured: got %h %h %h %h, want 005 7f9 3e7 000",
               captured[0], captured[1], captured[2], captured[3]);
    else n_pass++;
  endtask

  task automatic test_mismatch();
    bit ok;
    word_t w [3];
    w[0] = 11'd1; w[1] = 11'd9; w[2] = 11'd4;
    expected = '0;
    expected[0] = 11'd1; expected[1] = 11'd2; expected[2] = 11'd3;
    apply_reset(6'd3);
    for (int i = 0; i < 3; i++) begin
      send_word(w[i], ok);
      bus.write = 1'b0;
      @(negedge clk);
    end
    n_checks++;
    if (mismatch !== 1'b1 || err_idx !== 6'd1)
      $display("FAIL mismatch_flag: mm=%b err_idx=%0d, want 1 and 1", mismatch, err_idx);
    else n_pass++;
    n_checks++;
    if (done !== 1'b1 || count !== 6'd3 || captured[2] !== 11'd4)
      $display("FAIL mismatch_done: done=%b count=%0d cap2=%0d, want 1 3 4", done, count, captured[2]);
    else n_pass++;
  endtask

  task automatic test_overflow();
    bit ok, seen;
    expected = '0;
    expected[0] = 11'd10; expected[1] = 11'd20;
    apply_reset(6'd2);
    send_word(11'd10, ok);
    bus.write = 1'b0;
    @(negedge clk);
    send_word(11'd20, ok);
    bus.write = 1'b0;
    @(negedge clk);
    n_checks++;
    if (overflow !== 1'b0 || done !== 1'b1) $display("FAIL overflow_pre: ov=%b done=%b, want 0 1", overflow, done);
    else n_pass++;
    bus.write = 1'b1;
    bus.in    = 11'd30;
    seen = 1'b0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      seen |= bus.rready;
    end
    bus.write = 1'b0;
    n_checks++;
    if (seen !== 1'b0 || overflow !== 1'b1 || count !== 6'd2)
      $display("FAIL overflow_full: rready_seen=%b ov=%b count=%0d, want 0 1 2", seen, overflow, count);
    else n_pass++;
  endtask

  task automatic test_len_zero();
    bit seen;
    expected = '0;
    apply_reset(6'd0);
    bus.write = 1'b1;
    bus.in    = 11'd7;
    seen = 1'b0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      seen |= bus.rready;
    end
    bus.write = 1'b0;
    n_checks++;
    if (seen !== 1'b0 || done !== 1'b0 || overflow !== 1'b1 || count !== 6'd0)
      $display("FAIL len_zero: rready_seen=%b done=%b ov=%b count=%0d, want 0 0 1 0", seen, done, overflow, count);
    else n_pass++;
  endtask

  task automatic test_back_to_back();
    bit ok;
    expected = '0;
    for (int i = 0; i < 4; i++) expected[i] = 11'(100 + i);
    apply_reset(6'd4);
    for (int i = 0; i < 4; i++) send_word(11'(100 + i), ok);
    bus.write = 1'b0;
    @(negedge clk);
    n_checks++;
    if (hist[7:0] !== 8'b10101010) $display("FAIL b2b_pattern: rready=%b, want 10101010", hist[7:0]);
    else n_pass++;
    n_checks++;
    if (xfers != 4 || count !== 6'd4 || overflow !== 1'b0 || mismatch !== 1'b0)
      $display("FAIL b2b_status: xfers=%0d count=%0d ov=%b mm=%b, want 4 4 0 0", xfers, count, overflow, mismatch);
    else n_pass++;
    n_checks++;
    if (captured[0] !== 11'd100 || captured[3] !== 11'd103 || captured[4] !== 11'd0)
      $display("FAIL b2b_captured: got %0d %0d %0d, want 100 103 0", captured[0], captured[3], captured[4]);
    else n_pass++;
  endtask

  task automatic test_reset_mid();
    bit ok;
    expected = '0;
    expected[0] = 11'd11; expected[1] = 11'd22; expected[2] = 11'd33;
    apply_reset(6'd3);
    send_word(11'd11, ok);
    bus.write = 1'b0;
    @(negedge clk);
    bus.write = 1'b1;
    bus.in    = 11'd22;
    @(negedge clk);
    n_checks++;
    if (bus.rready !== 1'b1 || count !== 6'd1) $display("FAIL mid_pre: rready=%b count=%0d, want 1 1", bus.rready, count);
    else n_pass++;
    rst = 1'b1;
    #1;
    n_checks++;
    if (bus.rready !== 1'b0 || count !== 6'd0 || captured !== '0 || mismatch !== 1'b0 || overflow !== 1'b0)
      $display("FAIL mid_async: rready=%b count=%0d mm=%b ov=%b, want all 0", bus.rready, count, mismatch, overflow);
    else n_pass++;
    @(negedge clk);
    bus.write = 1'b0;
    rst = 1'b0;
    @(negedge clk);
    n_checks++;
    if (count !== 6'd0) $display("FAIL mid_no_take: count=%0d, want 0", count);
    else n_pass++;
    for (int i = 0; i < 3; i++) begin
      send_word(11'(11 * (i + 1)), ok);
      bus.write = 1'b0;
      @(negedge clk);
    end
    n_checks++;
    if (count !== 6'd3 || done !== 1'b1 || mismatch !== 1'b0 || captured[1] !== 11'd22 || captured[2] !== 11'd33)
      $display("FAIL mid_resend: count=%0d done=%b mm=%b c1=%0d c2=%0d, want 3 1 0 22 33",
               count, done, mismatch, captured[1], captured[2]);
    else n_pass++;
  endtask

  initial begin
    rst       = 1'b1;
    length    = '0;
    expected  = '0;
    bus.write = 1'b0;
    bus.in    = '0;
    hist      = '0;
    xfers     = 0;
    test_reset();
    test_match();
    test_mismatch();
    test_overflow();
    test_len_zero();
    test_back_to_back();
    test_reset_mid();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
